// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - RV32 opcode constants, decode enums and immediate helpers shared by the decode stage.
package core_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef enum logic [3:0] {
        CLS_ALU_REG, CLS_ALU_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_UPPER, CLS_SYSTEM, CLS_FENCE, CLS_UNKNOWN
    } inst_class_e;

    function automatic inst_class_e classify(input logic [6:0] opc);
        inst_class_e cls;
        case (opc)
            OPC_LUI, OPC_AUIPC: cls = CLS_UPPER;
            OPC_JAL:            cls = CLS_JAL;
            OPC_JALR:           cls = CLS_JALR;
            OPC_BRANCH:         cls = CLS_BRANCH;
            OPC_LOAD:           cls = CLS_LOAD;
            OPC_STORE:          cls = CLS_STORE;
            OPC_OP_IMM:         cls = CLS_ALU_IMM;
            OPC_OP:             cls = CLS_ALU_REG;
            OPC_SYSTEM:         cls = CLS_SYSTEM;
            OPC_MISC_MEM:       cls = CLS_FENCE;
            default:            cls = CLS_UNKNOWN;
        endcase
        return cls;
    endfunction

    function automatic imm_fmt_e imm_format(input inst_class_e cls);
        imm_fmt_e fmt;
        case (cls)
            CLS_UPPER:                                             fmt = IMM_U;
            CLS_JAL:                                               fmt = IMM_J;
            CLS_BRANCH:                                            fmt = IMM_B;
            CLS_STORE:                                             fmt = IMM_S;
            CLS_JALR, CLS_LOAD, CLS_ALU_IMM, CLS_SYSTEM, CLS_FENCE: fmt = IMM_I;
            default:                                               fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - DEPTH-entry FIFO with stream handshakes and a flush that empties it at the next edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             push;
    logic             pop;

    // Extra pointer bit tells full from empty when the index bits coincide.
    assign s_tready = !((wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]));
    assign m_tvalid = (wptr != rptr);
    assign push     = s_tvalid && s_tready && !flush;
    assign pop      = m_tvalid && m_tready && !flush;
    assign m_tdata  = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wptr[AW-1:0]] <= s_tdata;
    end

endmodule

// File: rtl/decode_stage_fwd.sv
// rtl/decode_stage_fwd.sv - Buffered decode stage with operand forwarding, load-use stall and flush.
module decode_stage_fwd
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int NFWD  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_imm,
    output logic                 out_rd_wen,
    output logic [4:0]           rf_rs1_addr,
    output logic [4:0]           rf_rs2_addr,
    input  logic [XLEN-1:0]      rf_rs1_data,
    input  logic [XLEN-1:0]      rf_rs2_data,
    input  logic [NFWD-1:0]      fwd_wen,
    input  logic [NFWD-1:0]      fwd_is_load,
    input  logic [5*NFWD-1:0]    fwd_rd,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic [XLEN-1:0]      out_rs1_data,
    output logic [XLEN-1:0]      out_rs2_data,
    input  logic                 flush,
    output logic [31:0]          cnt_issue,
    output logic [31:0]          cnt_stall,
    output logic [31:0]          cnt_flush
);

    localparam int EW = 32 + XLEN;

    logic              head_valid;
    logic [EW-1:0]     head;
    logic              pop;
    logic              stall;
    inst_class_e       cls;
    logic signed [31:0] imm32;
    logic              rs1_used;
    logic              rs2_used;
    logic              rs1_load;
    logic              rs2_load;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .s_tvalid (in_valid),
        .s_tready (in_ready),
        .s_tdata  ({in_inst, in_pc}),
        .m_tvalid (head_valid),
        .m_tready (pop),
        .m_tdata  (head)
    );

    // Empty head reads as all-zero so nothing stale leaks to execute.
    assign out_inst    = head_valid ? head[EW-1 -: 32] : 32'h0;
    assign out_pc      = head_valid ? head[XLEN-1:0] : '0;
    assign cls         = classify(out_inst[6:0]);
    assign imm32       = gen_imm(out_inst, imm_format(cls));
    assign out_imm     = XLEN'(imm32);
    assign rs1_used    = !(cls inside {CLS_UPPER, CLS_JAL});
    assign rs2_used    = cls inside {CLS_ALU_REG, CLS_BRANCH, CLS_STORE};
    assign out_rd_wen  = (cls inside {CLS_ALU_REG, CLS_ALU_IMM, CLS_LOAD, CLS_JAL,
                                      CLS_JALR, CLS_UPPER, CLS_SYSTEM})
                         && (out_inst[11:7] != 5'd0);
    assign rf_rs1_addr = out_inst[19:15];
    assign rf_rs2_addr = out_inst[24:20];

    // Walk from oldest to youngest so the youngest matching stage wins.
    always_comb begin
        out_rs1_data = rf_rs1_data;
        out_rs2_data = rf_rs2_data;
        rs1_load     = 1'b0;
        rs2_load     = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_wen[i] && (fwd_rd[5*i +: 5] == rf_rs1_addr)) begin
                out_rs1_data = fwd_data[XLEN*i +: XLEN];
                rs1_load     = fwd_is_load[i];
            end
            if (fwd_wen[i] && (fwd_rd[5*i +: 5] == rf_rs2_addr)) begin
                out_rs2_data = fwd_data[XLEN*i +: XLEN];
                rs2_load     = fwd_is_load[i];
            end
        end
        if (rf_rs1_addr == 5'd0) begin
            out_rs1_data = '0;
            rs1_load     = 1'b0;
        end
        if (rf_rs2_addr == 5'd0) begin
            out_rs2_data = '0;
            rs2_load     = 1'b0;
        end
    end

    assign stall     = head_valid && ((rs1_used && rs1_load) || (rs2_used && rs2_load));
    assign out_valid = head_valid && !stall && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_issue <= '0;
            cnt_stall <= '0;
            cnt_flush <= '0;
        end else begin
            if (pop)   cnt_issue <= cnt_issue + 32'd1;
            if (stall) cnt_stall <= cnt_stall + 32'd1;
            if (flush) cnt_flush <= cnt_flush + 32'd1;
        end
    end

endmodule

// File: tb/tb_decode_stage_fwd.sv
// tb/tb_decode_stage_fwd.sv - Directed scenarios plus randomized run against a queue-based reference model.
module tb_decode_stage_fwd;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int NFWD  = 3;

    logic                 clock;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [XLEN-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_inst;
    logic [XLEN-1:0]      out_pc;
    logic [XLEN-1:0]      out_imm;
    logic                 out_rd_wen;
    logic [4:0]           rf_rs1_addr;
    logic [4:0]           rf_rs2_addr;
    logic [XLEN-1:0]      rf_rs1_data;
    logic [XLEN-1:0]      rf_rs2_data;
    logic [NFWD-1:0]      fwd_wen;
    logic [NFWD-1:0]      fwd_is_load;
    logic [5*NFWD-1:0]    fwd_rd;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic [XLEN-1:0]      out_rs1_data;
    logic [XLEN-1:0]      out_rs2_data;
    logic                 flush;
    logic [31:0]          cnt_issue;
    logic [31:0]          cnt_stall;
    logic [31:0]          cnt_flush;

    int total;
    int bad;

    decode_stage_fwd #(.XLEN(XLEN), .DEPTH(DEPTH), .NFWD(NFWD)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_imm(out_imm), .out_rd_wen(out_rd_wen),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .fwd_wen(fwd_wen), .fwd_is_load(fwd_is_load), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .flush(flush), .cnt_issue(cnt_issue), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0; flush = 0;
        rf_rs1_data = 0; rf_rs2_data = 0;
        fwd_wen = 0; fwd_is_load = 0; fwd_rd = 0; fwd_data = 0;
    endtask

    // Reference decode: immediate format letter and operand/dest usage by opcode.
    function automatic void ref_decode(input logic [6:0] op, output byte fmt,
                                       output bit u1, output bit u2, output bit wr);
        fmt = "R"; u1 = 1; u2 = 0; wr = 0;
        case (op)
            7'h37, 7'h17: begin fmt = "U"; u1 = 0; wr = 1; end
            7'h6f:        begin fmt = "J"; u1 = 0; wr = 1; end
            7'h67, 7'h03, 7'h13, 7'h73: begin fmt = "I"; wr = 1; end
            7'h0f:        fmt = "I";
            7'h63:        begin fmt = "B"; u2 = 1; end
            7'h23:        begin fmt = "S"; u2 = 1; end
            7'h33:        begin u2 = 1; wr = 1; end
            default:      ;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] x);
        byte fmt; bit u1, u2, wr;
        int  sgn;
        int  r;
        ref_decode(x[6:0], fmt, u1, u2, wr);
        sgn = int'($signed(x) >>> 31);
        case (fmt)
            "I": r = int'($signed(x) >>> 20);
            "S": r = int'($signed(x) >>> 25) * 32 + int'(x[11:7]);
            "B": r = sgn * 4096 + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
            "U": r = int'(x & 32'hffff_f000);
            "J": r = sgn * 1048576 + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic void ref_operand(input logic [4:0] r, input logic [XLEN-1:0] rf,
                                        output logic [XLEN-1:0] d, output bit ld);
        d = rf; ld = 0;
        if (r == 0) begin d = 0; return; end
        for (int i = 0; i < NFWD; i++) begin
            if (fwd_wen[i] && fwd_rd[5*i +: 5] == r) begin
                d = fwd_data[XLEN*i +: XLEN]; ld = fwd_is_load[i]; return;
            end
        end
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [11];
        logic [31:0] x;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};
        x = $urandom;
        x[19:15] = 5'($urandom_range(0, 7));
        x[24:20] = 5'($urandom_range(0, 7));
        x[11:7]  = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 9) != 0) x[6:0] = ops[$urandom_range(0, 10)];
        return x;
    endfunction

    logic [31:0]     iq[$];
    logic [XLEN-1:0] pq[$];
    logic [31:0]     m_issue, m_stall, m_flush;

    initial begin
        logic [31:0]     h, t;
        logic [XLEN-1:0] hp, e1, e2;
        byte fmt; bit u1, u2, wr, l1, l2, stl, ev;

        total = 0; bad = 0;
        idle();
        reset = 1;
        repeat (2) @(negedge clock);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_cnt_issue", cnt_issue, 0);
        check("rst_cnt_stall", cnt_stall, 0);
        check("rst_cnt_flush", cnt_flush, 0);
        @(negedge clock); reset = 0;

        // ADDI x1,x0,5 issues the cycle after the push
        in_valid = 1; in_inst = 32'h0050_0093; in_pc = 32'h8000_0000; out_ready = 1;
        #1 check("addi_same_cycle", out_valid, 0);
        @(negedge clock); in_valid = 0; #1;
        check("addi_valid", out_valid, 1);
        check("addi_imm", out_imm, 5);
        check("addi_rd_wen", out_rd_wen, 1);
        check("addi_pc", out_pc, 32'h8000_0000);
        @(negedge clock); #1;
        check("addi_issue", cnt_issue, 1);
        check("addi_drained", out_valid, 0);

        // ADD x3,x1,x2 with two matching sources: youngest wins
        out_ready = 0; in_valid = 1; in_inst = 32'h0020_81b3; in_pc = 32'h8000_0004;
        @(negedge clock);
        in_valid = 0; fwd_wen = 3'b101; fwd_rd = {5'd1, 5'd0, 5'd1};
        fwd_data = {32'd9, 32'd0, 32'd7};
        #1;
        check("fwd_youngest", out_rs1_data, 7);
        check("fwd_rs2_rf", out_rs2_data, 0);
        check("fwd_valid", out_valid, 1);
        check("fwd_rs1_addr", rf_rs1_addr, 1);
        check("fwd_rs2_addr", rf_rs2_addr, 2);
        out_ready = 1;
        @(negedge clock); idle(); #1;
        check("fwd_issue", cnt_issue, 2);

        // load-use on x5 for three cycles
        in_valid = 1; in_inst = 32'h0002_8333; in_pc = 32'h8000_0008; out_ready = 1;
        @(negedge clock);
        in_valid = 0; fwd_wen = 3'b010; fwd_rd = {5'd0, 5'd5, 5'd0};
        fwd_is_load = 3'b010; fwd_data = {32'd0, 32'h55, 32'd0};
        for (int k = 0; k < 3; k++) begin
            #1 check("stall_valid", out_valid, 0);
            @(negedge clock);
        end
        fwd_is_load = 0; #1;
        check("stall_release", out_valid, 1);
        check("stall_data", out_rs1_data, 32'h55);
        check("stall_count", cnt_stall, 3);
        @(negedge clock); idle(); #1;
        check("stall_issue", cnt_issue, 3);

        // backpressure with DEPTH=2
        for (int k = 0; k < 3; k++) begin
            t = 32'h93 + 32'((k + 1) << 20);
            in_valid = 1; in_inst = t; in_pc = XLEN'(k);
            #1 check("bp_in_ready", in_ready, (k < 2) ? 1 : 0);
            @(negedge clock);
        end
        out_ready = 1; #1;
        check("bp_full", in_ready, 0);
        check("bp_head_a", out_imm, 1);
        @(negedge clock); out_ready = 0; #1;
        check("bp_reopen", in_ready, 1);
        check("bp_head_b", out_imm, 2);
        @(negedge clock); in_valid = 0; out_ready = 1; #1;
        check("bp_head_b2", out_imm, 2);
        @(negedge clock); #1;
        check("bp_head_c", out_imm, 3);
        @(negedge clock); out_ready = 0; #1;
        check("bp_empty", out_valid, 0);
        check("bp_issue", cnt_issue, 6);

        // flush with two entries and a coincident push
        in_valid = 1; in_inst = 32'h0010_0093;
        @(negedge clock); in_inst = 32'h0020_0093;
        @(negedge clock); flush = 1; in_inst = 32'h0030_0093; #1;
        check("flush_valid", out_valid, 0);
        @(negedge clock); flush = 0; in_valid = 0; out_ready = 1; #1;
        check("flush_empty", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_count", cnt_flush, 1);
        @(negedge clock); #1;
        check("flush_no_issue", cnt_issue, 6);

        // reset mid-stream
        out_ready = 0; in_valid = 1; in_inst = 32'h0010_0093;
        @(negedge clock); in_valid = 0; reset = 1; #1;
        check("mid_rst_issue", cnt_issue, 0);
        check("mid_rst_stall", cnt_stall, 0);
        check("mid_rst_flush", cnt_flush, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clock); reset = 0; out_ready = 1; #1;
        check("post_rst_valid", out_valid, 0);
        @(negedge clock); #1;
        check("post_rst_issue", cnt_issue, 0);

        // randomized run against the queue model
        m_issue = 0; m_stall = 0; m_flush = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if (reset) begin
                reset = 0;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1; #1;
                check("r_rst_valid", out_valid, 0);
                check("r_rst_ready", in_ready, 1);
                check("r_rst_issue", cnt_issue, 0);
                iq.delete(); pq.delete();
                m_issue = 0; m_stall = 0; m_flush = 0;
                continue;
            end
            in_valid    = ($urandom_range(0, 2) != 0);
            in_inst     = rand_inst();
            in_pc       = XLEN'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            rf_rs1_data = XLEN'($urandom);
            rf_rs2_data = XLEN'($urandom);
            fwd_wen     = NFWD'($urandom);
            for (int i = 0; i < NFWD; i++) begin
                fwd_is_load[i]           = ($urandom_range(0, 7) == 0);
                fwd_rd[5*i +: 5]         = 5'($urandom_range(0, 7));
                fwd_data[XLEN*i +: XLEN] = XLEN'($urandom);
            end
            #1;
            h  = (iq.size() != 0) ? iq[0] : 32'h0;
            hp = (pq.size() != 0) ? pq[0] : '0;
            ref_decode(h[6:0], fmt, u1, u2, wr);
            ref_operand(h[19:15], rf_rs1_data, e1, l1);
            ref_operand(h[24:20], rf_rs2_data, e2, l2);
            stl = (iq.size() != 0) && ((u1 && l1) || (u2 && l2));
            ev  = (iq.size() != 0) && !stl && !flush;
            check("r_in_ready", in_ready, (iq.size() < DEPTH) ? 1 : 0);
            check("r_out_valid", out_valid, ev);
            check("r_out_inst", out_inst, h);
            check("r_out_pc", out_pc, hp);
            check("r_out_imm", out_imm, ref_imm(h));
            check("r_rd_wen", out_rd_wen, wr && (h[11:7] != 0));
            check("r_rs1_addr", rf_rs1_addr, h[19:15]);
            check("r_rs2_addr", rf_rs2_addr, h[24:20]);
            check("r_rs1_data", out_rs1_data, e1);
            check("r_rs2_data", out_rs2_data, e2);
            check("r_cnt_issue", cnt_issue, m_issue);
            check("r_cnt_stall", cnt_stall, m_stall);
            check("r_cnt_flush", cnt_flush, m_flush);
            if (stl) m_stall++;
            if (flush) begin
                m_flush++;
                iq.delete(); pq.delete();
            end else begin
                bit was_full;
                was_full = (iq.size() == DEPTH);
                if (ev && out_ready) begin
                    m_issue++;
                    void'(iq.pop_front()); void'(pq.pop_front());
                end
                if (in_valid && !was_full) begin
                    iq.push_back(in_inst); pq.push_back(in_pc);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_fwd.md
DECODE_STAGE_FWD -- requirements
Module: decode_stage_fwd

Interface
REQ-001 SHALL take parameter XLEN, default 32: datapath width.
REQ-002 SHALL take parameter DEPTH, default 2: input buffer entries, power of two, 2 or more.
REQ-003 SHALL take parameter NFWD, default 3: forwarding sources; index 0 is the youngest stage.
REQ-004 SHALL have port clock  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid / in_ready  in / out  1 / 1  fetch handshake.
REQ-007 SHALL have port in_inst / in_pc  in  32 / XLEN  fetched instruction and its PC.
REQ-008 SHALL have port out_valid / out_ready  out / in  1 / 1  execute handshake.
REQ-009 SHALL have port out_inst / out_pc / out_imm  out  32 / XLEN / XLEN  head instruction, its PC, and its sign-extended immediate.
REQ-010 SHALL have port out_rd_wen  out  1  head writes rd, and rd is not x0.
REQ-011 SHALL have port rf_rs1_addr / rf_rs2_addr  out  5 / 5  register-file read addresses.
REQ-012 SHALL have port rf_rs1_data / rf_rs2_data  in  XLEN / XLEN  register-file read data.
REQ-013 SHALL have port fwd_wen / fwd_is_load  in  NFWD / NFWD  per source: writes rd / is a load whose data is not yet available.
REQ-014 SHALL have port fwd_rd / fwd_data  in  5*NFWD / XLEN*NFWD  per-source destination register and result.
REQ-015 SHALL have port out_rs1_data / out_rs2_data  out  XLEN / XLEN  forwarded operands.
REQ-016 SHALL have port flush  in  1  control-hazard redirect.
REQ-017 SHALL have port cnt_issue / cnt_stall / cnt_flush  out  32 each  performance counters.

Function
REQ-018 SHALL buffer instructions in a DEPTH-entry FIFO; in_ready = !full; push on in_valid && in_ready.
REQ-019 SHALL decode the FIFO head combinationally; a pushed instruction appears at out_* no earlier than the next cycle.
REQ-020 SHALL drive rs1 as used for all opcodes except LUI, AUIPC and JAL; rs2 as used only for R-type, B-type and S-type.
REQ-021 SHALL produce immediates in I/S/B/U/J formats by opcode, and 0 for R-type and unknown opcodes.
REQ-022 SHALL forward each operand from the lowest index i with fwd_wen[i], matching fwd_rd[i], and fwd_rd[i] != 0; with no match it SHALL use rf data; x0 always reads 0.
REQ-023 SHALL raise an internal stall when the selected source has fwd_is_load=1; out_valid SHALL be 0 while stalled, and cnt_stall SHALL increment by 1 per stalled cycle that has a non-empty head.
REQ-024 SHALL set out_valid = !empty && !stall && !flush; pop on out_valid && out_ready; cnt_issue SHALL increment per pop.
REQ-025 SHALL hold out_* stable while out_valid && !out_ready.
REQ-026 SHALL force out_valid=0 in the flush cycle, empty the FIFO at the next edge, drop any same-cycle push, and increment cnt_flush by 1.
REQ-027 SHALL allow push and pop in the same cycle, including when the FIFO is full? No: push requires in_ready, so no push occurs when the FIFO is full.
REQ-028 SHALL let all counters wrap modulo 2^32 without saturating.

Reset
REQ-029 SHALL on reset empty the FIFO, zero the pointers and counters, and hold in_ready=1 and out_valid=0; out_inst, out_pc and out_imm SHALL be 0.
REQ-030 SHALL discard in-flight entries when reset asserts mid-operation; there SHALL be no pop after reset deassertion until a new push.

Structure
REQ-031 SHALL place the opcode constants, immediate-format enum and instruction-class enum in shared package core_pkg.
REQ-032 SHALL implement the FIFO as sub-module sync_fifo (WIDTH, DEPTH) with a flush port.

Verification
REQ-033 Push ADDI x1,x0,5 (0x00500093) at pc 0x80000000, out_ready=1 -> out_valid the next cycle, out_imm=5, out_rd_wen=1, cnt_issue=1.
REQ-034 Head ADD x3,x1,x2 with fwd0 (rd=1, data 7) and fwd2 (rd=1, data 9) both matching, rf=0 -> out_rs1_data=7.
REQ-035 Head uses x5 and fwd1 is a load on rd=5 for 3 cycles -> out_valid=0 for 3 cycles, cnt_stall=3, then issue with the forwarded data.
REQ-036 DEPTH=2, out_ready=0, push 3 instructions -> in_ready=0 after 2 pushes; the third is accepted after one pop.
REQ-037 FIFO holds 2 entries, flush coincides with in_valid -> out_valid=0 in that cycle, FIFO empty the next cycle, cnt_flush=1, nothing issued.
REQ-038 Assert reset mid-stream for 1 cycle -> all counters 0, out_valid=0, in_ready=1.
